// File: rtl/ram_mar_responder.sv
// MAR + RAM bus responder with a byte-stream program loader for the 8-bit CPU.
// Optional macro RAM_CLEAR_ON_RESET_EN: asynchronous reset also zeroes the RAM.
module ram_mar_responder #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              mar_load,
    input  logic              ram_out,
    input  logic              ram_write,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar_value,
    output logic              bus_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                conflict_q, conflict_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        mar_d      = mar_q;
        ptr_d      = ptr_q;
        conflict_d = conflict_q;
        mem_we     = 1'b0;
        mem_waddr  = mar_q;
        mem_wdata  = bus_in;
        bus_oe     = 1'b0;
        prog_ready = 1'b0;
        prog_done  = 1'b0;

        unique case (state_q)
            RUN: begin
                bus_oe = ram_out & ~rst;
                if (mar_load) mar_d = bus_in[ADDR_W-1:0];
                // A read always wins over a simultaneous write; the clash is latched as an error.
                if (ram_write && ram_out) conflict_d = 1'b1;
                else if (ram_write)       mem_we     = 1'b1;
                if (prog_mode) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                prog_ready = ~rst;
                if (prog_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = prog_data;
                    if (ptr_q == {ADDR_W{1'b1}}) state_d = DONE;
                    else                         ptr_d   = ptr_q + 1'b1;
                end
                if (!prog_mode) state_d = RUN;
            end
            DONE: begin
                prog_done = ~rst;
                if (!prog_mode) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        bus_out = bus_oe ? mem[mar_q] : '0;
    end

    assign mar_value    = mar_q;
    assign bus_conflict = conflict_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            mar_q      <= '0;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mar_q      <= mar_d;
            ptr_q      <= ptr_d;
            conflict_q <= conflict_d;
        end
    end

`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
`else
    // NOTE: the RAM array is deliberately left without reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
`endif

endmodule

// File: tb/tb_ram_mar_responder.sv
// Directed self-checking bench for ram_mar_responder.
module tb_ram_mar_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       mar_load, ram_out, ram_write;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_done;
    logic [3:0] mar_value;
    logic       bus_conflict;

    int checks = 0;
    int errors = 0;

    ram_mar_responder #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .mar_load(mar_load), .ram_out(ram_out), .ram_write(ram_write),
        .prog_mode(prog_mode), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .prog_done(prog_done), .mar_value(mar_value),
        .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [7:0] v);
        mar_load = 1'b1; bus_in = v;
        tick();
        mar_load = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] v);
        ram_write = 1'b1; bus_in = v;
        tick();
        ram_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        set_mar({4'h0, a});
        ram_out = 1'b1;
        #1;
        check(tag, {bus_oe, bus_out}, {1'b1, exp});
        ram_out = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; bus_in = '0; mar_load = 0; ram_out = 1'b1; ram_write = 0;
        prog_mode = 0; prog_valid = 0; prog_data = '0;
        #12;
        check("reset_mar", mar_value, 0);
        check("reset_oe_out", {bus_oe, bus_out}, 0);
        check("reset_prog", {prog_ready, prog_done}, 0);
        check("reset_conflict", bus_conflict, 0);
        ram_out = 1'b0;
        rst = 1'b0;
        tick();

        // Bus write then same-cycle read
        set_mar(8'hF5);
        check("mar_upper_ignored", mar_value, 5);
        bus_write(8'h3C);
        ram_out = 1'b1;
        #1;
        check("read_zero_latency", {bus_oe, bus_out}, {1'b1, 8'h3C});
        ram_out = 1'b0;
        #1;
        check("oe_low_out_zero", {bus_oe, bus_out}, 0);

        // Simultaneous controls
        set_mar(8'h07);
        bus_write(8'hAA);
        set_mar(8'h02);
        bus_write(8'h11);
        mar_load = 1'b1; ram_write = 1'b1; bus_in = 8'h07;
        tick();
        mar_load = 1'b0; ram_write = 1'b0;
        check("load_write_mar", mar_value, 7);
        check("no_conflict_yet", bus_conflict, 0);
        ram_out = 1'b1; ram_write = 1'b1; bus_in = 8'h55;
        #1;
        check("conflict_read_served", bus_out, 8'hAA);
        tick();
        ram_write = 1'b0;
        check("conflict_set", bus_conflict, 1);
        check("conflict_write_suppressed", bus_out, 8'hAA);
        ram_out = 1'b0;
        tick();
        check("conflict_sticky", bus_conflict, 1);
        read_check("old_mar_write", 4'd2, 8'h07);

        // Program load, gapped valid
        prog_mode = 1'b1;
        tick();
        check("load_ready", prog_ready, 1);
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1'b1; prog_data = 8'(i);
            tick();
            prog_valid = 1'b0;
            if (i == 14) check("not_done_early", prog_done, 0);
            tick();
        end
        check("load_done", {prog_ready, prog_done}, 2'b01);
        prog_valid = 1'b1; prog_data = 8'hFF;
        tick();
        prog_valid = 1'b0;
        check("done_holds", {prog_ready, prog_done, bus_oe}, 3'b010);
        prog_mode = 1'b0;
        tick();
        check("back_to_run", {prog_ready, prog_done}, 0);
        for (int i = 0; i < 16; i++) read_check($sformatf("prog_rd%0d", i), 4'(i), 8'(i));

        // Abort mid-load with CPU controls active
        prog_mode = 1'b1;
        tick();
        mar_load = 1'b1; ram_write = 1'b1; ram_out = 1'b1; bus_in = 8'hE3;
        for (int i = 0; i < 6; i++) begin
            prog_valid = 1'b1; prog_data = 8'hA0 + 8'(i);
            #1;
            check("load_no_oe", {bus_oe, bus_out}, 0);
            tick();
            prog_valid = 1'b0;
            tick();
        end
        mar_load = 1'b0; ram_write = 1'b0; ram_out = 1'b0;
        check("load_mar_frozen", mar_value, 15);
        prog_mode = 1'b0;
        tick();
        check("abort_run", {prog_ready, prog_done}, 0);
        for (int i = 0; i < 16; i++)
            read_check($sformatf("abort_rd%0d", i), 4'(i), (i < 6) ? 8'hA0 + 8'(i) : 8'(i));

        // Asynchronous reset while in LOAD with MAR=9
        set_mar(8'h09);
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1; prog_data = 8'h50;
        tick();
        prog_valid = 1'b0;
        check("pre_reset_mar", mar_value, 9);
        #2 rst = 1'b1;
        #1;
        check("async_mar", mar_value, 0);
        check("async_outputs", {bus_oe, bus_out, prog_ready, prog_done, bus_conflict}, 0);
        prog_mode = 1'b0;
        #1 rst = 1'b0;
        tick();
        check("post_reset_ready", prog_ready, 0);
`ifdef RAM_CLEAR_ON_RESET_EN
        read_check("reset_ram0", 4'd0, 8'h00);
        read_check("reset_ram2", 4'd2, 8'h00);
`else
        read_check("reset_ram0", 4'd0, 8'h50);
        read_check("reset_ram2", 4'd2, 8'hA2);
`endif
        check("post_reset_conflict", bus_conflict, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_mar_responder.md
Name: ram_mar_responder

Overview:
- Bus responder for the 8-bit CPU: a memory address register (MAR) plus a 2^ADDR_W x DATA_W RAM.
- Answers the controller's bus requests: load address, drive data onto the shared bus, or write data from the bus.
- Includes a byte-stream program loader, fed from the top-level dedicated inputs, that fills RAM while the CPU is held.

Parameters:
- ADDR_W, 4, MAR width; RAM depth = 2^ADDR_W (16).
- DATA_W, 8, bus and RAM word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_in  input  DATA_W  current value of the shared CPU bus.
- bus_out  output  DATA_W  data this block drives onto the bus.
- bus_oe  output  1  high when bus_out is valid and this block owns the bus.
- mar_load  input  1  control: capture bus_in[ADDR_W-1:0] into MAR.
- ram_out  input  1  control: drive mem[MAR] onto the bus.
- ram_write  input  1  control: write bus_in into mem[MAR].
- prog_mode  input  1  level request to enter program-load mode.
- prog_valid  input  1  program byte is valid.
- prog_data  input  DATA_W  program byte.
- prog_ready  output  1  loader accepts a byte this cycle.
- prog_done  output  1  all 2^ADDR_W locations have been loaded.
- mar_value  output  ADDR_W  current MAR, for debug.
- bus_conflict  output  1  sticky error flag.

Behaviour:
- Reset (async, rst=1):
  - MAR=0, load pointer=0, state=RUN, bus_conflict=0.
  - bus_oe=0, bus_out=0, prog_ready=0, prog_done=0.
  - RAM contents are untouched, except as set by the Optional Feature.
- FSM states: RUN, LOAD, DONE.
  - RUN -> LOAD when prog_mode=1; the pointer clears to 0 on entry.
  - LOAD -> DONE after the byte at the last address is accepted.
  - LOAD -> RUN or DONE -> RUN as soon as prog_mode=0; RAM keeps whatever was written.
- RUN:
  - prog_ready=0, prog_done=0.
  - bus_out = mem[MAR] combinationally and bus_oe = ram_out, so data is valid in the same cycle ram_out is high (zero latency).
  - When bus_oe=0, bus_out=0.
  - mar_load: MAR <= bus_in[ADDR_W-1:0] at the edge; upper bus bits are ignored.
  - ram_write: mem[MAR] <= bus_in at the edge.
  - mar_load and ram_write in the same cycle: the write uses the old MAR, and MAR updates at the same edge.
  - ram_out and ram_write in the same cycle: the read is served, the write is suppressed, and bus_conflict is set to 1. It stays 1 until reset.
- LOAD:
  - prog_ready=1.
  - prog_valid & prog_ready: mem[ptr] <= prog_data, ptr <= ptr+1.
  - The accept that writes address 2^ADDR_W-1 moves the FSM to DONE. The pointer never wraps.
  - CPU controls (mar_load, ram_out, ram_write) are ignored, bus_oe=0, and MAR is unchanged.
- DONE:
  - prog_ready=0, prog_done=1, bus_oe=0.
  - prog_valid is ignored and RAM is unchanged.
- Reset mid-LOAD: the FSM returns to RUN immediately, and bytes already written are retained.
- rst has priority over every other input.

Optional Feature:
- Macro: RAM_CLEAR_ON_RESET_EN.
- Defined: async reset also clears every RAM word to 0.
- Undefined: RAM is not reset, and contents survive rst. The bench must load or write a location before reading it.

Test Plan:
- Bus write/read: mar_load with bus_in=8'hF5 (MAR=5), then ram_write with bus_in=8'h3C, then ram_out -> bus_out=8'h3C and bus_oe=1 in that same cycle; mar_value=5.
- Simultaneous controls: MAR=2 holding 8'h11; assert mar_load (bus_in=8'h07) and ram_write together -> mem[2]=8'h07 and MAR=7. Then assert ram_out and ram_write together -> bus_out=mem[7], mem[7] unchanged, bus_conflict=1 and sticky.
- Program load: prog_mode=1, then 16 bytes 8'h00..8'h0F with prog_valid gapped every other cycle -> prog_done=1 after the 16th accept, prog_ready=0. Drop prog_mode, then read addresses 0..15 via the bus -> values 0x00..0x0F.
- Abort mid-load: prog_mode drops after 6 bytes -> FSM in RUN with prog_ready=0. Addresses 0..5 hold the new bytes and 6..15 are unchanged. During LOAD, ram_write had no effect and bus_oe stayed 0.
- Reset mid-operation: rst pulsed asynchronously between clock edges while MAR=9 in LOAD -> MAR=0, outputs at reset values immediately. RAM is cleared only with RAM_CLEAR_ON_RESET_EN, otherwise retained. bus_conflict=0.
